// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exec_pkg
//  Purpose  : Shared constants for the execute stage: ALU control encoding,
//             instruction field positions and the default a0 mirror index.
//  Revision : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // ALU control encoding, identical to what the control unit drives
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Register-index fields inside a 32-bit instruction word
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;

    // Architectural register mirrored onto the a0 output (x10)
    localparam int A0_INDEX_DEFAULT = 10;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : exec_regfile
//  Purpose  : Architectural register file. Two asynchronous read ports, one
//             synchronous write port, x0 held at zero in storage, synchronous
//             active-high reset clearing every entry.
//  Revision : 1.0 - initial release
// ============================================================================
module exec_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage update: reset clears all, entry 0 is forced to zero every cycle,
    // other entries take wdata when addressed by an enabled write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst || (i == 0)) begin
                regs[i] <= '0;
            end else if (we && (waddr == ADDR_WIDTH'(i))) begin
                regs[i] <= wdata;
            end
        end
    end

    // Asynchronous reads return the pre-edge contents (no write bypass)
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule : exec_regfile
`default_nettype wire

// File: rtl/exec_top.sv
`default_nettype none
// ============================================================================
//  Module   : exec_top
//  Purpose  : Execute stage. Reads rs1/rs2 from the register file, selects
//             operand B (rs2 data or immediate), adds or subtracts, writes the
//             result back to rd and reports operand equality for branches.
//             Register x10 is mirrored onto the registered a0 output.
//  Revision : 1.0 - initial release
// ============================================================================
module exec_top
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int A0_INDEX       = A0_INDEX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic                  RegWrite,
    input  logic                  ALUctrl,
    input  logic                  ALUsrc,
    output logic                  EQ,
    output logic [DATA_WIDTH-1:0] a0
);

    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic [DATA_WIDTH-1:0]     sum;
    logic                      wr_en;
    logic                      a0_hit;
    logic                      unused_instr_bits;

    assign rs1 = instr[RS1_LSB +: REG_ADDR_WIDTH];
    assign rs2 = instr[RS2_LSB +: REG_ADDR_WIDTH];
    assign rd  = instr[RD_LSB  +: REG_ADDR_WIDTH];

    // Opcode/funct bits are decoded upstream; only register fields matter here
    assign unused_instr_bits = ^{instr[31:RS2_MSB+1], instr[RS1_LSB-1:RD_MSB+1],
                                 instr[RD_LSB-1:0]};

    // x0 writes are dropped inside the register file; gate here only on stall
    assign wr_en = en && RegWrite;

    exec_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .waddr  (rd),
        .wdata  (sum),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Operand selection, add/sub (wraps modulo 2**DATA_WIDTH) and equality
    always_comb begin
        op_a = rd1;
        op_b = ALUsrc ? ImmOp : rd2;
        sum  = (ALUctrl == ALU_SUB) ? (op_a - op_b) : (op_a + op_b);
        EQ   = (op_a == op_b);
    end

    // A write lands on the mirrored register only if it targets it and it is not x0
    assign a0_hit = wr_en && (rd == REG_ADDR_WIDTH'(A0_INDEX)) && (A0_INDEX != 0);

    // a0 tracks the next value of the mirrored register, so it updates on the
    // same edge the register file does and holds during stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            a0 <= '0;
        end else if (a0_hit) begin
            a0 <= sum;
        end
    end

endmodule : exec_top
`default_nettype wire
